output_port_arbiter: RTL and testbench
======================================

// Module: output_port_arbiter
// PURPOSE
//  One instance per router output port; 5 instances per router. Round-robin arbiter and packet-lock
//  controller between the 5 input datapaths and one output link. Drives the per-input grant,
//  output-available and output-ready bits the input datapaths consume.
//  Muxes the owning input's flits onto the link until that packet's tail flit transfers.
// PARAMETERS
//  NPORT    5   number of input ports (logic sized for 5; other values unsupported)
//  FLIT_W   16  flit width; type field = flit[FLIT_W-1:FLIT_W-2]
//  TIMEOUT  64  stall cycles before forced lock release (PKT_TIMEOUT_EN only), range 2..255
// PORTS
//  clk          in   1       clock, rising edge
//  reset        in   1       asynchronous, active-low reset
//  req          in   5       req[i]=requestPort bit of input i targeting this output
//  in0..in4     in   17      {valid, flit} from input i's dataOutN toward this output
//  down_ready   in   1       downstream link accepts a flit this cycle
//  grant        out  5       one-hot; input that owns this output (0 when idle)
//  available    out  1       output free for a new head flit (state IDLE)
//  out_ready    out  1       down_ready & (state BUSY); feeds inputs' outputReady bit
//  valid_out    out  1       flit valid on link
//  data_out     out  16      flit on link
//  pkt_done     out  1       1-cycle pulse: tail flit transferred
//  timeout_err  out  1       1-cycle pulse: lock forcibly released
// BEHAVIOUR
//  Flit type: 2'b11 head, 2'b00 body, 2'b01 tail, 2'b10 reserved (treated as body). Packets >=2 flits.
//  Transfer = valid_out & down_ready. valid_out = BUSY & owner valid bit; data_out = owner flit.
//  Both combinational from registered owner; data_out = 0 when IDLE.
//  FSM IDLE/BUSY, registered state, owner index (3b), rr_ptr (3b), one-hot grant.
//  IDLE: available=1, grant=0. If |req: winner = first set req scanning rr_ptr+1, +2, ... mod 5.
//   At the edge: grant<=onehot(winner), owner<=winner, state<=BUSY. Req-to-grant latency 1 cycle.
//  BUSY: available=0. Requests ignored, including owner's req dropping; lock held until tail.
//   On transfer of a tail flit: state<=IDLE, grant<=0, rr_ptr<=owner, pkt_done pulses next cycle.
//   Head/body transfers keep the lock. A head seen mid-packet is forwarded as body.
//  down_ready low: no transfer, data_out held to the owner's current flit, no state change.
//  Tail transfer with other reqs pending: one IDLE cycle, then re-arbitrate. The released owner
//   has lowest priority.
//  Single requester: wins every time regardless of rr_ptr.
//  Reset (async, active-low): state=IDLE, grant=0, owner=0, rr_ptr=4 (input 0 first).
//   pkt_done=0, timeout_err=0, stall counter=0, so available=1 and valid_out=0 while reset low.
//   Reset mid-packet aborts the lock; the in-flight packet is truncated (upstream recovery).
//  pkt_done and timeout_err are registered, never both high.
// CONFIGURATION
//  PKT_TIMEOUT_EN defined: 8-bit stall counter runs in BUSY, +1 each cycle without transfer.
//   Cleared on any transfer and on entry to BUSY.
//   When counter == TIMEOUT-1 and no transfer: state<=IDLE, grant<=0, rr_ptr<=owner,
//   timeout_err pulses next cycle.
//  PKT_TIMEOUT_EN undefined: no counter; lock held indefinitely; timeout_err tied 0.
// TESTING
//  T1 reset low with req=5'h1F -> grant=0, available=1, valid_out=0.
//   Release reset -> grant=5'b00001 one cycle later.
//  T2 input2 sends head,body,body,tail (0xC123,0x0001,0x0002,0x4003), down_ready=1.
//   -> grant=5'b00100 for 4 transfer cycles, data_out in order, pkt_done 1 cycle after tail, then IDLE.
//  T3 req=5'b10011 held, each owner sends 2-flit packet -> grant order 0,1,4,0.
//   One IDLE cycle between packets.
//  T4 down_ready toggled 1,0,0,1 mid-packet.
//   -> data_out stable while low, no flit lost or duplicated, lock kept.
//  T5 reset asserted after body flit of input3 packet -> grant=0, available=1 immediately.
//   Next req=5'b00001 wins in 1 cycle.
//  T6 (PKT_TIMEOUT_EN, TIMEOUT=8) owner valid=0 after head.
//   -> timeout_err pulses after 8 stall cycles, grant=0, next arbitration skips old owner.
//   Without macro: lock held 100 cycles, timeout_err=0.

Source files
------------

// File: rtl/output_port_arbiter_if.sv
// Bus between the five input datapaths, one router output port and its
// downstream link. The arbiter side takes the slave modport; whoever models
// the input datapaths and the link takes the master modport.
interface output_port_arbiter_if #(
    parameter int NPORT  = 5,
    parameter int FLIT_W = 16
);
    // Per-input request bits and {valid, flit} lanes toward this output
    logic [NPORT-1:0]  req;
    logic [FLIT_W:0]   in0;
    logic [FLIT_W:0]   in1;
    logic [FLIT_W:0]   in2;
    logic [FLIT_W:0]   in3;
    logic [FLIT_W:0]   in4;
    logic              down_ready;

    // Arbitration results and the outgoing link
    logic [NPORT-1:0]  grant;
    logic              available;
    logic              out_ready;
    logic              valid_out;
    logic [FLIT_W-1:0] data_out;
    logic              pkt_done;
    logic              timeout_err;

    modport master (
        output req, in0, in1, in2, in3, in4, down_ready,
        input  grant, available, out_ready, valid_out, data_out, pkt_done, timeout_err
    );

    modport slave (
        input  req, in0, in1, in2, in3, in4, down_ready,
        output grant, available, out_ready, valid_out, data_out, pkt_done, timeout_err
    );
endinterface

// File: rtl/output_port_arbiter.sv
// Round-robin arbiter and packet-lock controller for one router output port.
// The winning input owns the output link until its tail flit is accepted
// downstream; the owner's lane is muxed straight onto the link.
// Optional feature: define PKT_TIMEOUT_EN to add a stall counter that forcibly
// releases a lock after TIMEOUT cycles without a transfer.
module output_port_arbiter #(
    parameter int NPORT   = 5,
    parameter int FLIT_W  = 16,
    parameter int TIMEOUT = 64
) (
    input logic                  clk,
    input logic                  reset,
    output_port_arbiter_if.slave bus
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // The lane mux and round-robin scan are written for five inputs, and the
    // stall counter is eight bits wide, so reject anything else at elaboration.
    if (NPORT != 5 || TIMEOUT < 2 || TIMEOUT > 255) begin : gBadParam
        $error("output_port_arbiter: NPORT must be 5 and TIMEOUT within 2..255");
    end

    state_t           state_q;
    logic [2:0]       owner_q;
    logic [2:0]       rrPtr_q;
    logic [NPORT-1:0] grant_q;
    logic             pktDone_q;

`ifdef PKT_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_M1 = 8'(TIMEOUT - 1);
    logic [7:0]       stallCnt_q;
    logic             timeoutErr_q;
`endif

    logic [FLIT_W:0]   ownerLane;
    logic              ownerValid;
    logic [FLIT_W-1:0] ownerFlit;
    logic              busy;
    logic              validOut;
    logic              transfer;
    logic              isTail;
    logic              anyReq;
    logic [2:0]        winner_d;
    logic [NPORT-1:0]  grantOneHot_d;

    // Select the lane of the registered owner; unused owner codes read as idle
    always_comb begin
        ownerLane = '0;
        case (owner_q)
            3'd0:    ownerLane = bus.in0;
            3'd1:    ownerLane = bus.in1;
            3'd2:    ownerLane = bus.in2;
            3'd3:    ownerLane = bus.in3;
            3'd4:    ownerLane = bus.in4;
            default: ownerLane = '0;
        endcase
    end

    assign ownerValid = ownerLane[FLIT_W];
    assign ownerFlit  = ownerLane[FLIT_W-1:0];
    assign busy       = (state_q == BUSY);
    assign validOut   = busy & ownerValid;
    assign transfer   = validOut & bus.down_ready;
    assign isTail     = (ownerFlit[FLIT_W-1 -: 2] == 2'b01);
    assign anyReq     = |bus.req;

    // Round-robin scan starting just after the last released owner, so the
    // most recent owner is checked last and a lone requester always wins
    always_comb begin
        logic       found;
        logic [2:0] cand;
        found    = 1'b0;
        cand     = '0;
        winner_d = rrPtr_q;
        for (int k = 1; k <= NPORT; k++) begin
            cand = 3'((int'(rrPtr_q) + k) % NPORT);
            if (!found && bus.req[cand]) begin
                found    = 1'b1;
                winner_d = cand;
            end
        end
    end

    assign grantOneHot_d = {{(NPORT-1){1'b0}}, 1'b1} << winner_d;

    // Lock FSM: grant on a request in IDLE, hold until the tail is accepted
    // (or the stall limit expires), then hand priority past the released owner
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            owner_q      <= 3'd0;
            rrPtr_q      <= 3'd4;
            grant_q      <= '0;
            pktDone_q    <= 1'b0;
`ifdef PKT_TIMEOUT_EN
            stallCnt_q   <= 8'd0;
            timeoutErr_q <= 1'b0;
`endif
        end else begin
            pktDone_q    <= 1'b0;
`ifdef PKT_TIMEOUT_EN
            timeoutErr_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (anyReq) begin
                        state_q    <= BUSY;
                        grant_q    <= grantOneHot_d;
                        owner_q    <= winner_d;
`ifdef PKT_TIMEOUT_EN
                        stallCnt_q <= 8'd0;
`endif
                    end
                end
                BUSY: begin
                    if (transfer) begin
`ifdef PKT_TIMEOUT_EN
                        stallCnt_q <= 8'd0;
`endif
                        if (isTail) begin
                            state_q   <= IDLE;
                            grant_q   <= '0;
                            rrPtr_q   <= owner_q;
                            pktDone_q <= 1'b1;
                        end
                    end
`ifdef PKT_TIMEOUT_EN
                    else if (stallCnt_q == TIMEOUT_M1) begin
                        state_q      <= IDLE;
                        grant_q      <= '0;
                        rrPtr_q      <= owner_q;
                        timeoutErr_q <= 1'b1;
                        stallCnt_q   <= 8'd0;
                    end else begin
                        stallCnt_q   <= stallCnt_q + 8'd1;
                    end
`endif
                end
                default: begin
                    state_q <= IDLE;
                    grant_q <= '0;
                end
            endcase
        end
    end

    assign bus.grant     = grant_q;
    assign bus.available = (state_q == IDLE);
    assign bus.out_ready = bus.down_ready & busy;
    assign bus.valid_out = validOut;
    assign bus.data_out  = busy ? ownerFlit : '0;
    assign bus.pkt_done  = pktDone_q;
`ifdef PKT_TIMEOUT_EN
    assign bus.timeout_err = timeoutErr_q;
`else
    assign bus.timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_output_port_arbiter.sv
// Self-checking bench for output_port_arbiter. Models the five input
// datapaths as flit queues that advance when their flit is accepted, and
// checks every flit leaving on the link against a scoreboard of expected
// {owner, flit} pairs, plus directed checks on grant/available/pulses.
module tb_output_port_arbiter;

    localparam int NPORT   = 5;
    localparam int FLIT_W  = 16;
    localparam int TIMEOUT = 8;
    localparam int MEMD    = 128;

    typedef struct packed {
        logic [2:0]  owner;
        logic [15:0] flit;
    } sbEntry_t;

    typedef struct {
        int         port;
        int         len;
        logic [4:0] expGrant;
    } vec_t;

    logic clk = 1'b0;
    logic resetN;

    // Free-running clock, 10 time units per cycle
    always #5 clk = ~clk;

    output_port_arbiter_if #(.NPORT(NPORT), .FLIT_W(FLIT_W)) bus ();

    output_port_arbiter #(
        .NPORT  (NPORT),
        .FLIT_W (FLIT_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk  (clk),
        .reset(resetN),
        .bus  (bus)
    );

    logic [15:0] pktMem [NPORT][MEMD];
    int          wrPtr  [NPORT];
    int          rdPtr  [NPORT];
    logic [4:0]  reqForce;
    logic [4:0]  adv;
    logic        downReady;
    sbEntry_t    sbQ[$];
    int          nCompared   = 0;
    int          nMismatched = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Present each input's queue head and request bits to the arbiter
    task automatic applyStimulus();
        logic [16:0] lane [NPORT];
        for (int i = 0; i < NPORT; i++) begin
            if (rdPtr[i] < wrPtr[i]) lane[i] = {1'b1, pktMem[i][rdPtr[i]]};
            else                     lane[i] = '0;
            bus.req[i] = (rdPtr[i] < wrPtr[i]) || reqForce[i];
        end
        bus.in0        = lane[0];
        bus.in1        = lane[1];
        bus.in2        = lane[2];
        bus.in3        = lane[3];
        bus.in4        = lane[4];
        bus.down_ready = downReady;
    endtask

    // Advance past the active edge, consume accepted flits, re-drive inputs
    task automatic stepCycle();
        @(posedge clk);
        #1;
        for (int i = 0; i < NPORT; i++) begin
            if (adv[i]) begin
                rdPtr[i]++;
                adv[i] = 1'b0;
            end
        end
        applyStimulus();
        #1;
    endtask

    task automatic pushFlit(input int port, input logic [15:0] flit);
        pktMem[port][wrPtr[port]] = flit;
        wrPtr[port]++;
        sbQ.push_back('{owner: 3'(port), flit: flit});
    endtask

    // Build a packet: head, bodies cycling through body/reserved/mid-head
    // types, and a tail unless truncated
    task automatic pushPacket(input int port, input int len, input logic [7:0] tag, input bit truncated);
        logic [1:0] ty;
        for (int k = 0; k < len; k++) begin
            if (k == 0)                          ty = 2'b11;
            else if (k == len - 1 && !truncated) ty = 2'b01;
            else begin
                case (k % 3)
                    1:       ty = 2'b00;
                    2:       ty = 2'b10;
                    default: ty = 2'b11;
                endcase
            end
            pushFlit(port, {ty, 6'(k), tag});
        end
    endtask

    task automatic flushAll();
        for (int i = 0; i < NPORT; i++) rdPtr[i] = wrPtr[i];
        adv = '0;
        sbQ.delete();
    endtask

    task automatic doReset();
        resetN   = 1'b0;
        reqForce = '0;
        flushAll();
        applyStimulus();
        stepCycle();
        stepCycle();
        resetN = 1'b1;
        #1;
    endtask

    task automatic waitPktDone(input string name, input int maxCycles);
        logic seen;
        seen = 1'b0;
        for (int c = 0; c < maxCycles && !seen; c++) begin
            stepCycle();
            if (bus.pkt_done) seen = 1'b1;
        end
        checkOutput(name, 32'(seen), 32'd1);
    endtask

    // Link monitor: on every accepted flit, pop the expected owner/flit
    always @(negedge clk) begin
        sbEntry_t e;
        if (resetN && bus.valid_out && bus.down_ready) begin
            for (int i = 0; i < NPORT; i++) if (bus.grant[i]) adv[i] = 1'b1;
            if (sbQ.size() == 0) begin
                checkOutput("unexpected flit", 32'(bus.data_out), 32'hFFFF_FFFF);
            end else begin
                e = sbQ.pop_front();
                checkOutput("flit grant", 32'(bus.grant), 32'(5'b00001 << e.owner));
                checkOutput("flit data", 32'(bus.data_out), 32'(e.flit));
            end
        end
    end

    // Hard stop in case a sequence stalls
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t vecs [6];
        int   idleCnt;
        int   holdErr;

        vecs[0] = '{port: 3, len: 2, expGrant: 5'b01000};
        vecs[1] = '{port: 3, len: 3, expGrant: 5'b01000};
        vecs[2] = '{port: 0, len: 2, expGrant: 5'b00001};
        vecs[3] = '{port: 4, len: 5, expGrant: 5'b10000};
        vecs[4] = '{port: 2, len: 2, expGrant: 5'b00100};
        vecs[5] = '{port: 1, len: 4, expGrant: 5'b00010};

        resetN    = 1'b0;
        downReady = 1'b1;
        reqForce  = '0;
        adv       = '0;
        for (int i = 0; i < NPORT; i++) begin
            wrPtr[i] = 0;
            rdPtr[i] = 0;
        end
        applyStimulus();

        // T1: all requesting while reset is low, then first grant to input 0
        reqForce = 5'h1F;
        applyStimulus();
        stepCycle();
        stepCycle();
        checkOutput("reset grant", 32'(bus.grant), 32'd0);
        checkOutput("reset available", 32'(bus.available), 32'd1);
        checkOutput("reset valid_out", 32'(bus.valid_out), 32'd0);
        checkOutput("reset pkt_done", 32'(bus.pkt_done), 32'd0);
        checkOutput("reset timeout_err", 32'(bus.timeout_err), 32'd0);
        resetN = 1'b1;
        #1;
        checkOutput("grant before first edge", 32'(bus.grant), 32'd0);
        stepCycle();
        checkOutput("first grant", 32'(bus.grant), 32'b00001);
        checkOutput("first grant available", 32'(bus.available), 32'd0);
        reqForce = '0;
        pushPacket(0, 2, 8'hA0, 1'b0);
        applyStimulus();
        waitPktDone("T1 drain pkt_done", 10);
        doReset();

        // T3: inputs 0,1,4 requesting, grants must go 0,1,4,0 with idle gaps
        pushPacket(0, 2, 8'h30, 1'b0);
        pushPacket(1, 2, 8'h31, 1'b0);
        pushPacket(4, 2, 8'h34, 1'b0);
        pushPacket(0, 2, 8'h32, 1'b0);
        applyStimulus();
        idleCnt = 0;
        for (int c = 1; c <= 11; c++) begin
            stepCycle();
            if (bus.available) idleCnt++;
        end
        checkOutput("T3 idle gaps", 32'(idleCnt), 32'd3);
        stepCycle();
        checkOutput("T3 final pkt_done", 32'(bus.pkt_done), 32'd1);
        checkOutput("T3 all flits out", 32'(sbQ.size()), 32'd0);

        // T2: fixed four-flit packet from input 2
        pushFlit(2, 16'hC123);
        pushFlit(2, 16'h0001);
        pushFlit(2, 16'h0002);
        pushFlit(2, 16'h4003);
        applyStimulus();
        for (int c = 1; c <= 4; c++) begin
            stepCycle();
            checkOutput($sformatf("T2 grant c%0d", c), 32'(bus.grant), 32'b00100);
            checkOutput($sformatf("T2 available c%0d", c), 32'(bus.available), 32'd0);
        end
        stepCycle();
        checkOutput("T2 pkt_done", 32'(bus.pkt_done), 32'd1);
        checkOutput("T2 grant after tail", 32'(bus.grant), 32'd0);
        checkOutput("T2 available after tail", 32'(bus.available), 32'd1);
        checkOutput("T2 idle data_out", 32'(bus.data_out), 32'd0);
        checkOutput("T2 idle valid_out", 32'(bus.valid_out), 32'd0);
        stepCycle();
        checkOutput("T2 pkt_done one cycle", 32'(bus.pkt_done), 32'd0);

        // Table: lone requesters win regardless of where priority points
        for (int v = 0; v < 6; v++) begin
            pushPacket(vecs[v].port, vecs[v].len, 8'(8'hB0 + v), 1'b0);
            applyStimulus();
            stepCycle();
            checkOutput($sformatf("vec%0d grant", v), 32'(bus.grant), 32'(vecs[v].expGrant));
            waitPktDone($sformatf("vec%0d pkt_done", v), vecs[v].len + 4);
        end

        // T4: link back-pressure mid-packet holds the flit and the lock
        pushPacket(1, 4, 8'hD4, 1'b0);
        applyStimulus();
        stepCycle();
        checkOutput("T4 grant", 32'(bus.grant), 32'b00010);
        stepCycle();
        downReady = 1'b0;
        applyStimulus();
        #1;
        checkOutput("T4 out_ready low", 32'(bus.out_ready), 32'd0);
        for (int c = 0; c < 2; c++) begin
            stepCycle();
            checkOutput($sformatf("T4 held data c%0d", c), 32'(bus.data_out), 32'h01D4);
            checkOutput($sformatf("T4 held grant c%0d", c), 32'(bus.grant), 32'b00010);
            checkOutput($sformatf("T4 held valid c%0d", c), 32'(bus.valid_out), 32'd1);
        end
        downReady = 1'b1;
        applyStimulus();
        waitPktDone("T4 pkt_done", 10);
        checkOutput("T4 no flit lost", 32'(sbQ.size()), 32'd0);

        // T5: reset in the middle of an input 3 packet aborts the lock
        pushPacket(3, 2, 8'hE5, 1'b1);
        applyStimulus();
        stepCycle();
        stepCycle();
        stepCycle();
        checkOutput("T5 partial flits out", 32'(sbQ.size()), 32'd0);
        checkOutput("T5 lock held", 32'(bus.grant), 32'b01000);
        resetN = 1'b0;
        #1;
        checkOutput("T5 grant in reset", 32'(bus.grant), 32'd0);
        checkOutput("T5 available in reset", 32'(bus.available), 32'd1);
        checkOutput("T5 valid_out in reset", 32'(bus.valid_out), 32'd0);
        pushPacket(0, 2, 8'hE6, 1'b0);
        applyStimulus();
        stepCycle();
        resetN = 1'b1;
        #1;
        stepCycle();
        checkOutput("T5 grant after reset", 32'(bus.grant), 32'b00001);
        waitPktDone("T5 pkt_done", 10);

        // T6: owner goes silent after its head flit
        pushPacket(2, 1, 8'hF6, 1'b0);
        applyStimulus();
        stepCycle();
        checkOutput("T6 grant", 32'(bus.grant), 32'b00100);
        stepCycle();
        reqForce[2] = 1'b1;
        pushPacket(1, 2, 8'hF7, 1'b0);
        applyStimulus();
        holdErr = 0;
`ifdef PKT_TIMEOUT_EN
        for (int c = 1; c <= TIMEOUT - 1; c++) begin
            stepCycle();
            if (bus.timeout_err !== 1'b0 || bus.grant !== 5'b00100) holdErr++;
        end
        checkOutput("T6 lock before limit", 32'(holdErr), 32'd0);
        stepCycle();
        checkOutput("T6 timeout_err pulse", 32'(bus.timeout_err), 32'd1);
        checkOutput("T6 grant released", 32'(bus.grant), 32'd0);
        checkOutput("T6 available released", 32'(bus.available), 32'd1);
        checkOutput("T6 no pkt_done", 32'(bus.pkt_done), 32'd0);
        stepCycle();
        checkOutput("T6 old owner skipped", 32'(bus.grant), 32'b00010);
        checkOutput("T6 timeout_err one cycle", 32'(bus.timeout_err), 32'd0);
        waitPktDone("T6 next pkt_done", 10);
        checkOutput("T6 next packet out", 32'(sbQ.size()), 32'd0);
        doReset();
`else
        for (int c = 1; c <= 100; c++) begin
            stepCycle();
            if (bus.timeout_err !== 1'b0 || bus.grant !== 5'b00100 || bus.available !== 1'b0) holdErr++;
        end
        checkOutput("T6 lock held 100 cycles", 32'(holdErr), 32'd0);
        checkOutput("T6 waiting packet blocked", 32'(sbQ.size()), 32'd2);
        doReset();
`endif

        checkOutput("scoreboard empty", 32'(sbQ.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
